// File: rtl/duty_bcd_encoder_if.sv
// rtl/duty_bcd_encoder_if.sv - start/bin request and bcd/valid/busy response bundle
interface duty_bcd_encoder_if #(
  parameter int W      = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [W-1:0]          bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  valid;
  logic                  busy;

  modport master (output start, bin, input bcd, valid, busy);
  modport slave  (input start, bin, output bcd, valid, busy);
endinterface

// File: rtl/duty_bcd_encoder.sv
// rtl/duty_bcd_encoder.sv - serial double-dabble binary-to-packed-BCD converter
// One input bit per clock; bcd/valid/busy are all registered.
module duty_bcd_encoder #(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input logic               clk,
  input logic               rst,
  duty_bcd_encoder_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   shreg, shreg_nx;
  logic [BW-1:0]  scratch, scratch_nx;
  logic [BW-1:0]  corrected, shifted;
  logic [BW-1:0]  bcd_q, bcd_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           valid_q, valid_nx;
  logic           busy_q, busy_nx;

  // Add-3 is applied per nibble independently; no carry crosses a digit.
  always_comb begin
    corrected = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        corrected[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    shifted = {corrected[BW-2:0], shreg[W-1]};
  end

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    scratch_nx = scratch;
    cnt_nx     = cnt;
    bcd_nx     = bcd_q;
    valid_nx   = 1'b0;
    busy_nx    = busy_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          shreg_nx   = bus.bin;
          scratch_nx = '0;
          cnt_nx     = CW'(W);
          busy_nx    = 1'b1;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        shreg_nx   = {shreg[W-2:0], 1'b0};
        scratch_nx = shifted;
        cnt_nx     = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          bcd_nx   = shifted;
          valid_nx = 1'b1;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      scratch <= scratch_nx;
      cnt     <= cnt_nx;
      bcd_q   <= bcd_nx;
      valid_q <= valid_nx;
      busy_q  <= busy_nx;
    end
  end

  assign bus.bcd   = bcd_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_duty_bcd_encoder.sv
// tb/tb_duty_bcd_encoder.sv - scoreboard bench for W=8 and W=16 builds
module tb_duty_bcd_encoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  duty_bcd_encoder_if #(.W(8),  .DIGITS(3)) b8  ();
  duty_bcd_encoder_if #(.W(16), .DIGITS(5)) b16 ();

  duty_bcd_encoder #(.W(8),  .DIGITS(3)) dut8  (.clk(clk), .rst(rst), .bus(b8));
  duty_bcd_encoder #(.W(16), .DIGITS(5)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  typedef struct {
    logic [23:0] bcd;
    int          cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   busy_cnt8 = 0;
  int   vcnt8 = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (b8.busy) busy_cnt8++;
    if (b8.valid) begin
      vcnt8++;
      if (q8.size() == 0) chk("spurious_valid8", 1, 0);
      else begin
        e = q8.pop_front();
        chk("bcd8", 32'(b8.bcd), 32'(e.bcd));
        chk("latency8", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b16.valid) begin
      if (q16.size() == 0) chk("spurious_valid16", 1, 0);
      else begin
        e = q16.pop_front();
        chk("bcd16", 32'(b16.bcd), 32'(e.bcd));
        chk("latency16", cyc, e.cyc);
      end
    end
  end

  task automatic start8(input logic [7:0] v, input logic [23:0] e);
    b8.bin   = v;
    b8.start = 1'b1;
    q8.push_back('{e, cyc + 1 + 8});
    @(posedge clk); #1;
    b8.start = 1'b0;
  endtask

  task automatic wait8();
    int n = 0;
    while (!b8.valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!b8.valid) chk("timeout8", 0, 1);
  endtask

  task automatic start16(input logic [15:0] v, input logic [23:0] e);
    b16.bin   = v;
    b16.start = 1'b1;
    q16.push_back('{e, cyc + 1 + 16});
    @(posedge clk); #1;
    b16.start = 1'b0;
  endtask

  task automatic wait16();
    int n = 0;
    while (!b16.valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!b16.valid) chk("timeout16", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int v0;
    rst = 1'b1;
    b8.start = 1'b0;  b8.bin = '0;
    b16.start = 1'b0; b16.bin = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bcd", 32'(b8.bcd), 0);
    chk("rst_valid", 32'(b8.valid), 0);
    chk("rst_busy", 32'(b8.busy), 0);
    rst = 1'b0;

    // zero input, busy width
    busy_cnt8 = 0;
    start8(8'd0, 24'h000);
    wait8();
    @(negedge clk);
    chk("busy_cycles", busy_cnt8, 8);
    @(posedge clk); #1;

    // corner values
    start8(8'd255, 24'h255); wait8(); @(posedge clk); #1;
    start8(8'd99,  24'h099); wait8(); @(posedge clk); #1;
    start8(8'd100, 24'h100); wait8(); @(posedge clk); #1;
    start8(8'd9,   24'h009); wait8(); @(posedge clk); #1;
    start8(8'd10,  24'h010); wait8(); @(posedge clk); #1;

    // exhaustive back-to-back sweep, start issued in each valid cycle
    @(negedge clk);
    v0 = vcnt8;
    @(posedge clk); #1;
    for (int v = 0; v < 256; v++) begin
      start8(8'(v), to_bcd(v));
      wait8();
    end
    @(negedge clk); #1;
    chk("sweep_pulses", vcnt8 - v0, 256);
    @(posedge clk); #1;

    // start while busy is ignored, bin is not resampled
    v0 = vcnt8;
    start8(8'd37, 24'h037);
    repeat (2) begin @(posedge clk); #1; end
    b8.bin   = 8'd200;
    b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    wait8();
    repeat (6) begin @(posedge clk); #1; end
    chk("hold_bcd", 32'(b8.bcd), 32'h037);
    chk("busy_single_valid", vcnt8 - v0, 1);

    // mid-conversion reset aborts, then start on first edge after release
    start8(8'd128, 24'h128);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    q8.delete();
    #1;
    chk("abort_busy", 32'(b8.busy), 0);
    chk("abort_bcd", 32'(b8.bcd), 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_valid", 32'(b8.valid), 0);
    rst = 1'b0;
    start8(8'd64, 24'h064);
    wait8();
    @(posedge clk); #1;

    // wide build
    start16(16'd65535, 24'h065535); wait16(); @(posedge clk); #1;
    start16(16'd40960, 24'h040960); wait16(); @(posedge clk); #1;

    repeat (3) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q16_drained", q16.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/duty_bcd_encoder.md
# duty_bcd_encoder

Sequential binary-to-BCD encoder that converts the fuzzy controller's binary `duty` output back into packed BCD for the display and readback path. It is the reverse of the controller's `bcd` input conversion. It uses shift-and-add-3 (double-dabble), one bit per clock, with a start/valid handshake. It sits after `top`, so the duty value can be displayed in the same packed-BCD format the controller accepts on its input.

## Interface
- `W`, default 8: width of the binary input.
- `DIGITS`, default 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^W − 1 (3 for W=8, 5 for W=16). The implementation must be correct for W in 4..16.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a conversion. Sampled only while idle.
- `bin`  in  W: binary value (normally `duty`). Sampled on the same edge that accepts `start`.
- `bcd`  out  4*DIGITS: packed BCD result, most significant digit in the top nibble. Holds its value until the next conversion completes.
- `valid`  out  1: one-cycle pulse when `bcd` has just been updated.
- `busy`  out  1: high while a conversion is in progress.

## Operation
- FSM states: IDLE and SHIFT.
- **IDLE**
  - `start`=1 captures `bin` into a W-bit shift register, clears the 4*DIGITS scratch register, loads the bit counter with W, and moves to SHIFT.
  - `busy` goes high on that same edge.
- **SHIFT**, each cycle:
  - Every scratch nibble ≥ 5 first gets +3 (4-bit add, no carry between nibbles).
  - Then {scratch, shift register} shifts left by 1. The MSB of `bin` enters the scratch LSB.
  - The counter decrements by 1.
- **Last shift** (counter = 1):
  - `bcd` loads the corrected-and-shifted scratch value.
  - `valid` is set to 1, `busy` to 0, and the FSM returns to IDLE.
- `start` while in SHIFT is ignored: no queuing, and `bin` is not resampled.
- `valid` is high for exactly one cycle per completed conversion and is cleared on the next edge.
- Nibbles of `bcd` are always in 0..9. For W=8, the top nibble is in 0..2.
- `bin` may change freely after the accepting edge; the result reflects the captured value only.

## Timing
- Reset values: `bcd`=0, `valid`=0, `busy`=0, FSM=IDLE, counter=0, scratch and shift registers=0.
- Reset mid-conversion aborts immediately. No `valid` pulse follows, and `bcd` reads 0.
- Latency: with `start` accepted at edge E0, SHIFT runs on edges E1..EW. `bcd` and `valid` update at edge EW, so `valid` is high during the cycle after EW.
- `busy` is high from E0 through EW: W cycles.
- `start` asserted during the `valid` cycle is accepted at edge EW+1. The back-to-back conversion period is W+1 cycles (9 for W=8).
- Release of reset is asynchronous-assert and synchronous-use. A `start` sampled on the first edge after `rst` falls is accepted.
- `bcd` is registered, with no combinational path from `bin` or `start`. `valid` and `busy` are registered.

## Test plan
- **Zero input:** reset, then `bin`=0 with a 1-cycle `start` → after 8 edges, `valid` pulses once and `bcd`=0x000. `busy` is high for exactly 8 cycles.
- **Corner values:** `bin`=255 → `bcd`=0x255. `bin`=99 → 0x099. `bin`=100 → 0x100. `bin`=9 → 0x009. `bin`=10 → 0x010.
- **Exhaustive sweep:** run `bin` 0..255 back-to-back, asserting `start` in each `valid` cycle. Every result must equal the decimal value of `bin`, the period must be 9 cycles, and there are 256 `valid` pulses.
- **Busy handling:**
  - Start `bin`=37, then change `bin` to 200 and pulse `start` on cycle 3 → result 0x037, a single `valid`, and the second `start` is ignored.
  - `bcd` holds 0x037 until the next completion.
- **Mid-conversion reset:** start `bin`=128, assert `rst` on cycle 4 for 2 cycles → `busy`=0, `valid` stays 0, `bcd`=0x000. A new start with `bin`=64 → 0x064.
- **W=16 build:** with `DIGITS`=5, `bin`=65535 → `bcd`=0x65535 after 16 edges. `bin`=40960 → 0x40960.
